// File: rtl/ifid_pkg.sv
// ifid_pkg: shared types for the IF/ID pipeline stage.
//   immode_e       - 3-bit immediate format selector carried alongside each fetched word
//   ifid_payload_t - decoded IF/ID payload (register indices, immediate, PC) at the
//                    widest supported word size; narrower builds use the low bits.
package ifid_pkg;

  localparam int unsigned InsWidth    = 32;
  localparam int unsigned RegIdxWidth = 5;
  localparam int unsigned MaxWordSize = 64;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_CSR  = 3'd6,
    IMM_RSVD = 3'd7
  } immode_e;

  typedef struct packed {
    logic [RegIdxWidth-1:0] rdn;
    logic [RegIdxWidth-1:0] rs1n;
    logic [RegIdxWidth-1:0] rs2n;
    logic [MaxWordSize-1:0] imm;
    logic [MaxWordSize-1:0] pc;
  } ifid_payload_t;

endpackage

// File: rtl/ifid_imm_dec.sv
// ifid_imm_dec: purely combinational immediate decoder, shared with later stages.
//   ins    in  32        raw instruction word
//   immode in  3         immediate format (ifid_pkg::immode_e encoding)
//   imm    out WordSize  decoded immediate; sign-extended from ins[31] except CSR
module ifid_imm_dec
  import ifid_pkg::*;
#(
  parameter int unsigned WordSize = 32
) (
  input  logic [InsWidth-1:0] ins,
  input  logic [2:0]          immode,
  output logic [WordSize-1:0] imm
);

  // Opcode bits carry no immediate information.
  logic unused_opcode;
  assign unused_opcode = ^ins[6:0];

  // Sized casts of signed operands sign-extend to WordSize.
  always_comb begin
    imm = '0;
    case (immode_e'(immode))
      IMM_I:   imm = WordSize'($signed(ins[31:20]));
      IMM_S:   imm = WordSize'($signed({ins[31:25], ins[11:7]}));
      IMM_B:   imm = WordSize'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      IMM_U:   imm = WordSize'($signed({ins[31:12], 12'b0}));
      IMM_J:   imm = WordSize'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      IMM_CSR: imm = WordSize'(ins[19:15]);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ifid_pipe.sv
// ifid_pipe: valid/ready handshaked IF/ID stage with synchronous flush.
// Build option: define IFID_SKID_EN for a one-entry skid buffer and a registered
// in_ready (no combinational out_ready -> in_ready path).
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       fetch-side handshake
//   ins, pc_in, immode        fetched word, its PC, and its immediate format
//   flush                     drop every held and incoming instruction
//   out_valid / out_ready     decode-side handshake
//   rdn, rs1n, rs2n, imm, pc  decoded payload (registered)
module ifid_pipe
  import ifid_pkg::*;
#(
  parameter int unsigned WordSize = 32  // 32 or 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [InsWidth-1:0]    ins,
  input  logic [WordSize-1:0]    pc_in,
  input  logic [2:0]             immode,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RegIdxWidth-1:0] rdn,
  output logic [RegIdxWidth-1:0] rs1n,
  output logic [RegIdxWidth-1:0] rs2n,
  output logic [WordSize-1:0]    imm,
  output logic [WordSize-1:0]    pc
);

  logic [WordSize-1:0] imm_dec_c;
  ifid_payload_t       in_pld_c;
  ifid_payload_t       out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                in_xfer_c, out_xfer_c;

  ifid_imm_dec #(.WordSize(WordSize)) u_imm_dec (
    .ins    (ins),
    .immode (immode),
    .imm    (imm_dec_c)
  );

  // Decode on the way in; only the decoded fields are stored.
  always_comb begin
    in_pld_c      = '0;
    in_pld_c.rdn  = ins[11:7];
    in_pld_c.rs1n = ins[19:15];
    in_pld_c.rs2n = ins[24:20];
    in_pld_c.imm  = MaxWordSize'(imm_dec_c);
    in_pld_c.pc   = MaxWordSize'(pc_in);
  end

  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid_q && out_ready;

`ifdef IFID_SKID_EN
  ifid_payload_t skid_q, skid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q;

  assign in_ready = in_ready_q;

  // Next state: flush wins; a drain refills output from skid first; a stalled
  // output diverts the incoming word into the skid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer_c) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer_c) begin
        out_d = in_pld_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer_c) begin
      if (out_valid_q) begin
        skid_d       = in_pld_c;
        skid_valid_d = 1'b1;
      end else begin
        out_d       = in_pld_c;
        out_valid_d = 1'b1;
      end
    end
  end

  // State registers; in_ready tracks "skid empty" one edge behind the skid update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  if (WordSize < MaxWordSize) begin : g_skid_narrow
    logic unused_skid_hi;
    assign unused_skid_hi = ^{skid_q.imm[MaxWordSize-1:WordSize], skid_q.pc[MaxWordSize-1:WordSize]};
  end
`else
  // Without a skid the stage can take a word whenever the output frees this cycle.
  assign in_ready = !out_valid_q || out_ready;

  // Next state: flush wins; otherwise load on accept, empty on a bare drain.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_xfer_c) begin
      out_d       = in_pld_c;
      out_valid_d = 1'b1;
    end else if (out_xfer_c) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
`endif

  // Payload storage is sized for the widest build; narrow builds ignore the top bits.
  if (WordSize < MaxWordSize) begin : g_out_narrow
    logic unused_out_hi;
    assign unused_out_hi = ^{out_q.imm[MaxWordSize-1:WordSize], out_q.pc[MaxWordSize-1:WordSize]};
  end

  assign out_valid = out_valid_q;
  assign rdn       = out_q.rdn;
  assign rs1n      = out_q.rs1n;
  assign rs2n      = out_q.rs2n;
  assign imm       = out_q.imm[WordSize-1:0];
  assign pc        = out_q.pc[WordSize-1:0];

endmodule

// File: tb/tb_ifid_pipe.sv
// tb_ifid_pipe: directed vectors, handshake corner sequences and a randomized
// scoreboard run for ifid_pipe (WordSize = 32), in either IFID_SKID_EN build.
module tb_ifid_pipe;
  import ifid_pkg::*;

`ifdef IFID_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif
  localparam int unsigned W = 32;
  localparam int unsigned NRand = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]   ins;
  logic [W-1:0]  pc_in, imm, pc;
  logic [2:0]    immode;
  logic [4:0]    rdn, rs1n, rs2n;

  int n_cmp = 0;
  int n_err = 0;

  ifid_pipe #(.WordSize(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins       (ins),
    .pc_in     (pc_in),
    .immode    (immode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdn       (rdn),
    .rs1n      (rs1n),
    .rs2n      (rs2n),
    .imm       (imm),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  mode;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  mode;
    logic [31:0] pc;
  } inst_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample the handshake mid-cycle, then advance past the next rising edge.
  task automatic step_track(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  // Immediate reference: assemble the field value, then subtract the sign weight.
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] m);
    longint x, v;
    x = longint'(i);
    v = 0;
    case (m)
      3'd1: begin v = (x >> 20) & 64'h7FF; if (i[31]) v = v - 2048; end
      3'd2: begin v = (((x >> 25) & 64'h3F) << 5) | ((x >> 7) & 64'h1F); if (i[31]) v = v - 2048; end
      3'd3: begin
        v = (((x >> 7) & 64'h1) << 11) | (((x >> 25) & 64'h3F) << 5) | (((x >> 8) & 64'hF) << 1);
        if (i[31]) v = v - 4096;
      end
      3'd4: v = x & 64'hFFFF_F000;
      3'd5: begin
        v = (((x >> 12) & 64'hFF) << 12) | (((x >> 20) & 64'h1) << 11) | (((x >> 21) & 64'h3FF) << 1);
        if (i[31]) v = v - 1048576;
      end
      3'd6: v = (x >> 15) & 64'h1F;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t   vecs [9];
    inst_t  q [$];
    inst_t  h;
    bit     acc, b_acc, in_x, out_x;
    int     accepted, delivered, flushed;
    logic [31:0] next_pc;

    vecs[0] = '{32'hFFF0_0093, 3'd1, 5'd1,  5'd0,  5'd31, 32'hFFFF_FFFF};
    vecs[1] = '{32'h7FF0_0093, 3'd1, 5'd1,  5'd0,  5'd31, 32'h0000_07FF};
    vecs[2] = '{32'h8000_0F80, 3'd2, 5'd31, 5'd0,  5'd0,  32'hFFFF_F81F};
    vecs[3] = '{32'hFE00_0EE3, 3'd3, 5'd29, 5'd0,  5'd0,  32'hFFFF_FFFC};
    vecs[4] = '{32'h1234_5037, 3'd4, 5'd0,  5'd8,  5'd3,  32'h1234_5000};
    vecs[5] = '{32'hFF9F_F06F, 3'd5, 5'd0,  5'd31, 5'd25, 32'hFFFF_FFF8};
    vecs[6] = '{32'h800F_8073, 3'd6, 5'd0,  5'd31, 5'd0,  32'h0000_001F};
    vecs[7] = '{32'hFFFF_FFFF, 3'd7, 5'd31, 5'd31, 5'd31, 32'h0000_0000};
    vecs[8] = '{32'hFFFF_FFFF, 3'd0, 5'd31, 5'd31, 5'd31, 32'h0000_0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    ins = '0; immode = '0; pc_in = '0;

    // Reset values
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_regs", 64'({rdn, rs1n, rs2n}), 64'(0));
    chk("rst_imm", 64'(imm), 64'(0));
    chk("rst_pc", 64'(pc), 64'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));

    // Back-to-back decode vectors at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      ins      = vecs[i].ins;
      immode   = vecs[i].mode;
      pc_in    = 32'h100 + 32'(i * 4);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("vec%0d_rdn", i), 64'(rdn), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_rs1n", i), 64'(rs1n), 64'(vecs[i].rs1));
      chk($sformatf("vec%0d_rs2n", i), 64'(rs2n), 64'(vecs[i].rs2));
      chk($sformatf("vec%0d_imm", i), 64'(imm), 64'(vecs[i].imm));
      chk($sformatf("vec%0d_pc", i), 64'(pc), 64'(32'h100 + 32'(i * 4)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("vec_drain", 64'(out_valid), 64'(0));

    // Backpressure: A held, B waits (or sits in the skid), then A, B in order
    out_ready = 1'b0; in_valid = 1'b1;
    ins = 32'hFFF0_0093; immode = 3'd1; pc_in = 32'h200;
    step_track(acc);
    chk("bp_a_acc", 64'(acc), 64'(1));
    ins = 32'h1234_5037; immode = 3'd4; pc_in = 32'h204;
    step_track(acc);
    b_acc = acc;
    chk("bp_b_acc", 64'(acc), 64'(Skid));
    if (acc) in_valid = 1'b0;
    chk("bp_a_valid", 64'(out_valid), 64'(1));
    chk("bp_a_pc", 64'(pc), 64'(32'h200));
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    step_track(acc);
    if (acc) begin b_acc = 1'b1; in_valid = 1'b0; end
    chk("bp_a_stable_pc", 64'(pc), 64'(32'h200));
    chk("bp_a_stable_imm", 64'(imm), 64'(32'hFFFF_FFFF));
    out_ready = 1'b1;
    step_track(acc);
    if (acc) b_acc = 1'b1;
    in_valid = 1'b0;
    chk("bp_b_taken", 64'(b_acc), 64'(1));
    chk("bp_b_valid", 64'(out_valid), 64'(1));
    chk("bp_b_pc", 64'(pc), 64'(32'h204));
    chk("bp_b_imm", 64'(imm), 64'(32'h1234_5000));
    chk("bp_in_ready_back", 64'(in_ready), 64'(1));
    step_track(acc);
    chk("bp_empty", 64'(out_valid), 64'(0));

    // Flush with the stage full and a word arriving
    out_ready = 1'b0; in_valid = 1'b1;
    ins = 32'hFFFF_FFFF; immode = 3'd1; pc_in = 32'h300;
    step_track(acc);
    pc_in = 32'h304;
    step_track(acc);
    flush = 1'b1; pc_in = 32'h308;
    step_track(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_track(acc);
      chk("fl_no_ghost", 64'(out_valid), 64'(0));
    end
    // Flush with an empty stage drops the incoming word
    in_valid = 1'b1; flush = 1'b1; pc_in = 32'h30C;
    step_track(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_empty_drop", 64'(out_valid), 64'(0));
    step_track(acc);
    chk("fl_empty_drop2", 64'(out_valid), 64'(0));

    // Asynchronous reset mid-cycle clears outputs before the next edge
    out_ready = 1'b0; in_valid = 1'b1;
    ins = 32'hFFFF_FFFF; immode = 3'd1; pc_in = 32'h400;
    step_track(acc);
    in_valid = 1'b0;
    chk("ar_loaded_valid", 64'(out_valid), 64'(1));
    chk("ar_loaded_pc", 64'(pc), 64'(32'h400));
    #3 rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'(0));
    chk("ar_regs", 64'({rdn, rs1n, rs2n}), 64'(0));
    chk("ar_imm", 64'(imm), 64'(0));
    chk("ar_pc", 64'(pc), 64'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_after_valid", 64'(out_valid), 64'(0));
    chk("ar_after_in_ready", 64'(in_ready), 64'(1));

    // Randomized traffic against a queue model of held instructions
    accepted = 0; delivered = 0; flushed = 0;
    next_pc = 32'h1000;
    for (int c = 0; c < int'(NRand) + 4; c++) begin
      @(posedge clk); #1;
      if (c < int'(NRand)) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 99) < 6);
        ins       = $urandom;
        immode    = 3'($urandom_range(0, 7));
        pc_in     = next_pc;
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end
      @(negedge clk);
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        h = q[0];
        chk("rnd_pc", 64'(pc), 64'(h.pc));
        chk("rnd_imm", 64'(imm), 64'(ref_imm(h.ins, h.mode)));
        chk("rnd_regs", 64'({rdn, rs1n, rs2n}),
            64'({h.ins[11:7], h.ins[19:15], h.ins[24:20]}));
      end
      if (Skid) chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
      else      chk("rnd_in_ready", 64'(in_ready), 64'(q.size() == 0 || out_ready));
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (flush) begin
        flushed += q.size();
        q.delete();
      end else begin
        if (out_x && q.size() != 0) begin
          void'(q.pop_front());
          delivered++;
        end
        if (in_x) begin
          q.push_back('{ins, immode, pc_in});
          accepted++;
        end
      end
      if (in_x) next_pc = next_pc + 32'd4;
    end
    chk("rnd_drained_valid", 64'(out_valid), 64'(0));
    chk("rnd_drained_model", 64'(q.size()), 64'(0));
    chk("rnd_exactly_once", 64'(delivered + flushed), 64'(accepted));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifid_pipe.md
# ifid_pipe

Parametrised IF/ID pipeline stage between fetch and decode. It replaces the fixed, always-advancing IF/ID register with a valid/ready handshaked stage. The stage extracts register indices, decodes the immediate to `WordSize` bits, and supports synchronous flush for branch redirects. An optional skid buffer registers the backpressure path.

## Interface
- `WordSize`, default 32: width of the PC and of the decoded immediate. Legal values are 32 or 64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `ins`  in  32  raw instruction word.
- `pc_in`  in  `WordSize`  PC of `ins`.
- `immode`  in  3  immediate format of `ins`, encoded with `ifid_pkg::immode_e`.
- `flush`  in  1  discard all held and incoming instructions.
- `out_valid`  out  1  decode-side payload valid.
- `out_ready`  in  1  decode accepts the payload.
- `rdn`, `rs1n`, `rs2n`  out  5 each  the fields `ins[11:7]`, `ins[19:15]` and `ins[24:20]`.
- `imm`  out  `WordSize`  decoded immediate.
- `pc`  out  `WordSize`  PC of the output instruction.

## Operation
- Input transfer happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- Decode is done combinationally on input. Only decoded fields are stored; `ins` itself is not stored.
- Immediate modes, each sign-extended from `ins[31]` to `WordSize` unless noted:
  - 0 NONE: 0.
  - 1 I: `ins[31:20]`.
  - 2 S: `{ins[31:25], ins[11:7]}`.
  - 3 B: `{ins[31], ins[7], ins[30:25], ins[11:8], 0}`.
  - 4 U: `{ins[31:12], 12'b0}`.
  - 5 J: `{ins[31], ins[19:12], ins[20], ins[30:21], 0}`. J is sign-extended, unlike the previous generation.
  - 6 CSR: `ins[19:15]`, zero-extended.
  - 7 reserved: 0.
- The output register loads when an input transfer occurs and either `!out_valid` or `out_ready` holds.
- Skid path (`IFID_SKID_EN`): an input accepted while the output is stalled (`out_valid && !out_ready`) goes to the one-entry skid register.
  - On the next output transfer, the skid contents move to the output register and the skid empties.
- Order is preserved; the stage holds at most 2 instructions.
- Flush has priority over everything. On the edge where `flush` is high:
  - `out_valid` and the skid valid bit are cleared.
  - Any input transfer that cycle is dropped. `in_ready` may still be high, and the fetch side treats the instruction as consumed.
  - Payload registers keep their contents, which are don't-care while invalid.
- While `out_valid && !out_ready`, all outputs hold stable.

## Timing
- Reset values: `out_valid`=0, `rdn`=`rs1n`=`rs2n`=0, `imm`=0, `pc`=0, skid empty. `in_ready` is 1 while `rst` is deasserted after reset.
- Latency: an input accepted at edge N gives `out_valid`=1 after edge N, with no skid occupancy.
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- `in_ready` with skid is a register equal to "skid empty". It drops the cycle after an instruction enters the skid, and rises the cycle after the skid drains.
- `in_ready` without skid is combinational: `!out_valid || out_ready`.
- Simultaneous output and input transfer with the skid full: the skid moves to output and the input is not accepted, since `in_ready` was 0.
- Reset asserted mid-operation: both entries are lost immediately (asynchronously). No handshake obligation survives reset.

## Configuration
- `IFID_SKID_EN` defined: one-entry skid buffer, registered `in_ready`, and no combinational path from `out_ready` to `in_ready`.
- `IFID_SKID_EN` not defined: no skid register, and `in_ready` is combinational from `out_ready`. Handshake semantics and latency are otherwise identical.

## Structure
- `ifid_pkg` holds:
  - `immode_e`, the 3-bit enum NONE, I, S, B, U, J, CSR, RSVD.
  - `ifid_payload_t`, a packed struct of `rdn`, `rs1n`, `rs2n`, `imm` and `pc`, using the maximum `WordSize` or parameterised through the module.
- One sub-module, `ifid_imm_dec`, is purely combinational: `ins` and `immode` in, `WordSize`-bit `imm` out. It is reused by later stages.

## Test plan
- Reset, then `ins`=0xFFF00093, `immode`=I, `pc_in`=0x100, `in_valid`=1, `out_ready`=1 -> next cycle `out_valid`=1, `rdn`=1, `rs1n`=0, `imm`=0xFFFFFFFF, `pc`=0x100.
- B-type 0xFE000EE3 -> `imm`=0xFFFFFFFC. J-type 0xFF9FF06F -> `imm`=0xFFFFFFF8. CSR with `ins[19:15]`=0x1F -> `imm`=0x1F. Mode 7 -> `imm`=0.
- `out_ready`=0 with back-to-back inputs A and B -> A held on outputs. With skid, B is accepted and `in_ready`=0 the next cycle. Raising `out_ready` -> A then B on consecutive cycles, with no loss or duplication.
- Skid full with `flush`=1 and `in_valid`=1 -> next cycle `out_valid`=0, skid empty, `in_ready`=1, and the incoming instruction never appears.
- `rst` pulsed asynchronously mid-cycle while `out_valid`=1 -> all outputs become 0 before the next edge.
- 1000 random `in_valid`/`out_ready`/`flush` cycles with a scoreboard -> in-order delivery, and every instruction not flushed is delivered exactly once, in both `IFID_SKID_EN` builds.
